// File: rtl/lstm_sram_pkg.sv
// Shared constants and state encoding for the weight/state SRAM feeders.
// The packer state enum is also used by the read-side sequencer.
package lstm_sram_pkg;
  localparam int WORD_W         = 32;
  localparam int LINE_W         = 512;
  localparam int ADDR_W         = 11;
  localparam int DEPTH          = 128;
  localparam int WORDS_PER_LINE = LINE_W / WORD_W;
  localparam int IDX_W          = $clog2(WORDS_PER_LINE);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    ISSUE  = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } packer_state_e;
endpackage

// File: rtl/sram_line_packer.sv
// sram_line_packer: packs a valid/ready stream of WORD_W words into LINE_W
// lines and writes each line to the SRAM at auto-incrementing addresses.
// DONE pulses once the SRAM has committed the final line to its array.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   START               job request, only looked at in IDLE
//   BASE_ADDR           first line address (taken mod DEPTH), latched on START
//   NUM_LINES           number of lines in the job (0 allowed), latched on START
//   IN_VALID/IN_DATA    word stream in
//   IN_READY            word accepted when IN_VALID & IN_READY
//   WE/ADDR_WRITE/DIN   one-cycle SRAM write per line
//   BUSY                high in every state but IDLE
//   DONE                one-cycle pulse, all lines committed
module sram_line_packer
  import lstm_sram_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [7:0]        NUM_LINES,
  input  logic              IN_VALID,
  input  logic [WORD_W-1:0] IN_DATA,
  output logic              IN_READY,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR_WRITE,
  output logic [LINE_W-1:0] DIN,
  output logic              BUSY,
  output logic              DONE
);

  packer_state_e                          r_state;
  logic [ADDR_W-1:0]                      r_addr;
  logic [7:0]                             r_left;
  logic [IDX_W-1:0]                       r_idx;
  // Only the first WORDS_PER_LINE-1 words are buffered; the last word goes
  // straight into the DIN register on the cycle it is accepted.
  logic [WORDS_PER_LINE-2:0][WORD_W-1:0]  r_words;
  logic [ADDR_W-1:0]                      r_addr_wr;
  logic [LINE_W-1:0]                      r_din;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_left    <= '0;
      r_idx     <= '0;
      r_words   <= '0;
      r_addr_wr <= '0;
      r_din     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (START) begin
            // Address kept at full port width so the upper bits are
            // provably zero rather than dropped.
            r_addr  <= BASE_ADDR % ADDR_W'(DEPTH);
            r_left  <= NUM_LINES;
            r_idx   <= '0;
            r_state <= (NUM_LINES == 8'd0) ? FINISH : FILL;
          end
        end
        FILL: begin
          if (IN_VALID) begin
            for (int k = 0; k < WORDS_PER_LINE-1; k++)
              if (r_idx == IDX_W'(k)) r_words[k] <= IN_DATA;
            if (r_idx == IDX_W'(WORDS_PER_LINE-1)) begin
              r_din     <= {IN_DATA, r_words};
              r_addr_wr <= r_addr;
              r_state   <= ISSUE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        ISSUE: begin
          r_addr  <= (r_addr == ADDR_W'(DEPTH-1)) ? '0 : r_addr + 1'b1;
          r_left  <= r_left - 1'b1;
          r_idx   <= '0;
          r_state <= (r_left == 8'd1) ? DRAIN : FILL;
        end
        // One cycle for the SRAM capture stage to push the last line into
        // the array before DONE is raised.
        DRAIN:   r_state <= FINISH;
        FINISH:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Status outputs decode straight from the state register; no path from
  // IN_VALID reaches IN_READY.
  assign IN_READY   = (r_state == FILL);
  assign WE         = (r_state == ISSUE);
  assign BUSY       = (r_state != IDLE);
  assign DONE       = (r_state == FINISH);
  assign ADDR_WRITE = r_addr_wr;
  assign DIN        = r_din;

endmodule
